dram_req_arbiter: RTL and testbench
===================================

# dram_req_arbiter

Shares the single DRAM controller command port between three line-refill requesters: the debug/monitor port, the D$ and the I$. The block sits between the caches' miss engines and the memory-side interface, and holds off every requester until `init_calib_complete` is high. Each transfer is one cache line, read or write. The block sequences each transfer through command issue, completion wait and done return.

## Interface
Parameters:
- `ADR_W`, default 28: line address width, byte address [31:4].
- `DATA_W`, default 128: line data width.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `init_calib_complete`  in  1  memory ready; no grant is issued while it is low.
- `dbg_req`, `dc_req`, `ic_req`  in  1 each  transfer request; held until the matching done.
- `dbg_we`, `dc_we`  in  1 each  write transfer (1) or read (0). The I$ is read-only.
- `dbg_adr`, `dc_adr`, `ic_adr`  in  ADR_W each  line address.
- `dbg_wdata`, `dc_wdata`  in  DATA_W each  write line data.
- `dbg_done`, `dc_done`, `ic_done`  out  1 each  one-cycle completion pulse.
- `rdata`  out  DATA_W  read line. Valid during a done pulse of a read; otherwise it holds its last value.
- `busy`  out  1  high in any state other than IDLE.
- `m_cmd_en`  out  1  command valid.
- `m_cmd_we`  out  1  command is a write.
- `m_adr`  out  ADR_W  command address.
- `m_wdata`  out  DATA_W  command write data.
- `m_cmd_rdy`  in  1  command accepted when both `m_cmd_en` and `m_cmd_rdy` are high.
- `m_done`  in  1  transfer complete pulse. On a read it accompanies `m_rdata`.
- `m_rdata`  in  DATA_W  read line.

## Operation
- States: IDLE, CMD, WAIT, DONE.
- IDLE to CMD: taken when `init_calib_complete` is high and at least one request is high.
  - The winner is latched into a one-hot grant register.
  - The winner's `we`, `adr` and `wdata` are captured into registers that drive `m_*`.
- Priority:
  - `dbg` always wins.
  - Between `dc` and `ic`: fixed or round-robin (see Configuration).
- CMD: `m_cmd_en` = 1. Moves to WAIT on the cycle where `m_cmd_rdy` = 1.
- WAIT: `m_cmd_en` = 0. On `m_done`:
  - `m_rdata` is captured into `rdata` for reads only.
  - Moves to DONE.
- DONE: pulses the granted requester's `*_done` for one cycle, then returns to IDLE and clears the grant.
- Requests are sampled only in IDLE.
  - A requester drops `req` in the cycle after its done pulse.
  - A request that falls while it is granted is ignored; the transfer completes normally.
- `m_done` arriving in IDLE or CMD is ignored.
- `init_calib_complete` falling during CMD or WAIT does not abort the transfer. It only blocks the next grant.
- Reset values:
  - All outputs 0, including `rdata`.
  - State IDLE, grant cleared, round-robin pointer set to `dc`.
- An asynchronous reset in mid-transfer returns the block to IDLE immediately. No done pulse is produced.

## Timing
- Request high in IDLE at cycle N: `m_cmd_en` = 1 at N+1.
- Command accepted at cycle C: WAIT from C+1.
- `m_done` at cycle M: `*_done` and `rdata` valid at M+1, IDLE at M+2.
- Minimum spacing between grants is 4 cycles: IDLE, CMD with `m_cmd_rdy` already high, WAIT with `m_done` arriving immediately, DONE.
- `busy` is registered and equals (state != IDLE).
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `ARB_RR_EN` defined:
  - `dc` and `ic` alternate when both are pending.
  - The pointer flips to the other cache after each cache grant.
  - `dbg` grants leave the pointer unchanged.
- `ARB_RR_EN` undefined:
  - Fixed priority `dbg` > `dc` > `ic`.
  - No pointer register.

## Test plan
- Single I$ read:
  - Stimulus: `ic_req` = 1, `ic_adr` = 28'h0000123, `m_cmd_rdy` = 1; `m_done` 5 cycles after accept with `m_rdata` = 128'hA5...A5.
  - Response: `m_cmd_en` for 1 cycle with `m_cmd_we` = 0 and `m_adr` = 28'h0000123; then `ic_done` for 1 cycle with `rdata` = A5...A5.
- D$ write with backpressure:
  - Stimulus: `dc_we` = 1, `m_cmd_rdy` low for 3 cycles.
  - Response: `m_cmd_en` held for 4 cycles with `m_wdata` stable; `dc_done` 1 cycle after `m_done`; `rdata` unchanged.
- Simultaneous requests:
  - Stimulus: `dbg`, `dc` and `ic` raised in the same cycle.
  - Response: grant order `dbg`, `dc`, `ic`, in both configurations.
- Starvation check:
  - Stimulus: `dc` and `ic` both held continuously, each re-requesting immediately after its done.
  - Response: with `ARB_RR_EN`, grants alternate `dc`, `ic`, `dc`, `ic`; without it, `dc` only.
- Calibration gating:
  - Stimulus: `init_calib_complete` = 0 with `ic_req` = 1 for 10 cycles, then raised.
  - Response: `m_cmd_en` stays 0 throughout, then goes high 1 cycle after calibration completes.
- Reset mid-transfer:
  - Stimulus: `rst_n` asserted in WAIT.
  - Response: all outputs 0 at once; no `*_done`; a fresh request after release is granted normally.

Source files
------------

// File: rtl/dram_req_arbiter.sv
// Arbitrates the DRAM command port between debug, D$ and I$ line-refill requesters.
// Define ARB_RR_EN for round-robin between D$ and I$; otherwise fixed dbg > dc > ic.
module dram_req_arbiter #(
  parameter int ADR_W  = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              dbg_req,
  input  logic              dc_req,
  input  logic              ic_req,
  input  logic              dbg_we,
  input  logic              dc_we,
  input  logic [ADR_W-1:0]  dbg_adr,
  input  logic [ADR_W-1:0]  dc_adr,
  input  logic [ADR_W-1:0]  ic_adr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dbg_done,
  output logic              dc_done,
  output logic              ic_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              m_cmd_en,
  output logic              m_cmd_we,
  output logic [ADR_W-1:0]  m_adr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_cmd_rdy,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          grant_q, grant_d;   // one-hot {ic, dc, dbg}
  logic [2:0]          done_q, done_d;
  logic                we_q, we_d;
  logic [ADR_W-1:0]    adr_q, adr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                cmd_en_q, cmd_en_d;
  logic                busy_q, busy_d;
  logic [2:0]          pick;

`ifdef ARB_RR_EN
  logic rr_q, rr_d;  // 0: D$ preferred next, 1: I$ preferred next

  always_comb begin
    if (dbg_req)               pick = 3'b001;
    else if (dc_req && ic_req) pick = rr_q ? 3'b100 : 3'b010;
    else if (dc_req)           pick = 3'b010;
    else if (ic_req)           pick = 3'b100;
    else                       pick = 3'b000;
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && init_calib_complete) begin
      if (pick[1]) rr_d = 1'b1;
      if (pick[2]) rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`else
  always_comb begin
    if (dbg_req)     pick = 3'b001;
    else if (dc_req) pick = 3'b010;
    else if (ic_req) pick = 3'b100;
    else             pick = 3'b000;
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (init_calib_complete && (|pick)) begin
          state_d = CMD;
          grant_d = pick;
          we_d    = pick[0] ? dbg_we    : (pick[1] ? dc_we    : 1'b0);
          adr_d   = pick[0] ? dbg_adr   : (pick[1] ? dc_adr   : ic_adr);
          wdata_d = pick[0] ? dbg_wdata : (pick[1] ? dc_wdata : '0);
        end
      end
      CMD: begin
        if (m_cmd_rdy) state_d = WAIT;
      end
      WAIT: begin
        if (m_done) begin
          state_d = DONE;
          if (!we_q) rdata_d = m_rdata;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies of what the next state implies.
    cmd_en_d = (state_d == CMD);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE) ? grant_q : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 3'b000;
      done_q   <= 3'b000;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cmd_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cmd_en_q <= cmd_en_d;
      busy_q   <= busy_d;
    end
  end

  assign dbg_done = done_q[0];
  assign dc_done  = done_q[1];
  assign ic_done  = done_q[2];
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign m_cmd_en = cmd_en_q;
  assign m_cmd_we = we_q;
  assign m_adr    = adr_q;
  assign m_wdata  = wdata_q;

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed self-checking bench for dram_req_arbiter; expectations follow ARB_RR_EN.
module tb_dram_req_arbiter;
  localparam int ADR_W  = 28;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              init_calib_complete;
  logic              dbg_req, dc_req, ic_req;
  logic              dbg_we, dc_we;
  logic [ADR_W-1:0]  dbg_adr, dc_adr, ic_adr;
  logic [DATA_W-1:0] dbg_wdata, dc_wdata;
  logic              dbg_done, dc_done, ic_done;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              m_cmd_en, m_cmd_we;
  logic [ADR_W-1:0]  m_adr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_cmd_rdy, m_done;
  logic [DATA_W-1:0] m_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [ADR_W-1:0]  A_DBG = 28'h0000DB0;
  localparam logic [ADR_W-1:0]  A_DC  = 28'h0000DC0;
  localparam logic [ADR_W-1:0]  A_IC  = 28'h0000123;
  localparam logic [DATA_W-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [DATA_W-1:0] PAT_5A = {16{8'h5A}};
  localparam logic [DATA_W-1:0] PAT_W  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  dram_req_arbiter #(.ADR_W(ADR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .dbg_req(dbg_req), .dc_req(dc_req), .ic_req(ic_req),
    .dbg_we(dbg_we), .dc_we(dc_we),
    .dbg_adr(dbg_adr), .dc_adr(dc_adr), .ic_adr(ic_adr),
    .dbg_wdata(dbg_wdata), .dc_wdata(dc_wdata),
    .dbg_done(dbg_done), .dc_done(dc_done), .ic_done(ic_done),
    .rdata(rdata), .busy(busy),
    .m_cmd_en(m_cmd_en), .m_cmd_we(m_cmd_we), .m_adr(m_adr), .m_wdata(m_wdata),
    .m_cmd_rdy(m_cmd_rdy), .m_done(m_done), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] done_vec();
    return {ic_done, dc_done, dbg_done};
  endfunction

  // Runs one read transfer from IDLE with m_cmd_rdy high and an immediate m_done.
  task automatic serve(input string tag, input logic [2:0] exp, input bit drop);
    logic [ADR_W-1:0]  ea;
    logic [DATA_W-1:0] rd;
    ea = exp[0] ? A_DBG : (exp[1] ? A_DC : A_IC);
    rd = {100'd0, ea};
    m_cmd_rdy = 1'b1;
    tick();
    check({tag, ".cmd_en"}, m_cmd_en, 1'b1);
    check({tag, ".adr"}, m_adr, ea);
    tick();
    check({tag, ".wait_en"}, m_cmd_en, 1'b0);
    m_done = 1'b1;
    m_rdata = rd;
    tick();
    m_done = 1'b0;
    check({tag, ".done"}, done_vec(), exp);
    check({tag, ".rdata"}, rdata, rd);
    $display("txn %s: grant=%b adr=%0h rdata=%0h", tag, done_vec(), m_adr, rdata);
    if (drop) begin
      if (exp[0]) dbg_req = 1'b0;
      if (exp[1]) dc_req = 1'b0;
      if (exp[2]) ic_req = 1'b0;
    end
    tick();
    check({tag, ".done_clr"}, done_vec(), 3'b000);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] starve_exp [4];
`ifdef ARB_RR_EN
    starve_exp = '{3'b010, 3'b100, 3'b010, 3'b100};
`else
    starve_exp = '{3'b010, 3'b010, 3'b010, 3'b010};
`endif
    init_calib_complete = 1'b1;
    {dbg_req, dc_req, ic_req, dbg_we, dc_we} = '0;
    dbg_adr = A_DBG; dc_adr = A_DC; ic_adr = A_IC;
    dbg_wdata = '0; dc_wdata = '0;
    m_cmd_rdy = 1'b0; m_done = 1'b0; m_rdata = '0;
    reset_dut();

    // Reset state
    check("rst.cmd_en", m_cmd_en, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.rdata", rdata, '0);
    check("rst.adr", m_adr, '0);
    check("rst.done", done_vec(), 3'b000);

    // Single I$ read
    ic_req = 1'b1; m_cmd_rdy = 1'b1;
    tick();
    check("ic.cmd_en", m_cmd_en, 1'b1);
    check("ic.we", m_cmd_we, 1'b0);
    check("ic.adr", m_adr, A_IC);
    check("ic.busy", busy, 1'b1);
    tick();
    check("ic.cmd_en_1cyc", m_cmd_en, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ic.wait", done_vec(), 3'b000);
    end
    m_done = 1'b1; m_rdata = PAT_A5;
    tick();
    m_done = 1'b0; ic_req = 1'b0;
    check("ic.done", done_vec(), 3'b100);
    check("ic.rdata", rdata, PAT_A5);
    $display("txn ic_read: adr=%0h rdata=%0h", m_adr, rdata);
    tick();
    check("ic.done_1cyc", done_vec(), 3'b000);
    check("ic.idle", busy, 1'b0);

    // m_done in IDLE is ignored
    m_done = 1'b1; m_rdata = PAT_5A;
    tick();
    m_done = 1'b0;
    check("idle_mdone.busy", busy, 1'b0);
    check("idle_mdone.rdata", rdata, PAT_A5);

    // D$ write with backpressure
    dc_we = 1'b1; dc_wdata = PAT_W; dc_req = 1'b1; m_cmd_rdy = 1'b0;
    tick();
    check("dcw.cmd_en", m_cmd_en, 1'b1);
    check("dcw.we", m_cmd_we, 1'b1);
    check("dcw.wdata", m_wdata, PAT_W);
    m_done = 1'b1;  // stray m_done while in CMD
    tick();
    m_done = 1'b0;
    check("dcw.hold2", m_cmd_en, 1'b1);
    tick();
    check("dcw.hold3", m_cmd_en, 1'b1);
    check("dcw.cmd_mdone_ignored", done_vec(), 3'b000);
    tick();
    check("dcw.hold4", m_cmd_en, 1'b1);
    check("dcw.wdata_stable", m_wdata, PAT_W);
    m_cmd_rdy = 1'b1;
    tick();
    check("dcw.wait_en", m_cmd_en, 1'b0);
    m_done = 1'b1; m_rdata = PAT_5A;
    tick();
    m_done = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    check("dcw.done", done_vec(), 3'b010);
    check("dcw.rdata_kept", rdata, PAT_A5);
    $display("txn dc_write: adr=%0h wdata=%0h", m_adr, m_wdata);
    tick();
    check("dcw.idle", busy, 1'b0);

    // Simultaneous requests
    reset_dut();
    dbg_req = 1'b1; dc_req = 1'b1; ic_req = 1'b1;
    serve("sim0", 3'b001, 1'b1);
    serve("sim1", 3'b010, 1'b1);
    serve("sim2", 3'b100, 1'b1);

    // Starvation: D$ and I$ held continuously
    dc_req = 1'b1; ic_req = 1'b1;
    for (int i = 0; i < 4; i++) serve("starve", starve_exp[i], 1'b0);
    dc_req = 1'b0; ic_req = 1'b0;
    tick();
    check("starve.idle", busy, 1'b0);

    // Calibration gating
    init_calib_complete = 1'b0; ic_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("calib.blocked", m_cmd_en, 1'b0);
    end
    init_calib_complete = 1'b1;
    serve("calib", 3'b100, 1'b1);

    // Reset in WAIT
    dc_req = 1'b1; m_cmd_rdy = 1'b1;
    tick();
    tick();
    check("rstw.in_wait", busy, 1'b1);
    check("rstw.wait_en", m_cmd_en, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rstw.cmd_en", m_cmd_en, 1'b0);
    check("rstw.busy", busy, 1'b0);
    check("rstw.adr", m_adr, '0);
    check("rstw.rdata", rdata, '0);
    check("rstw.done", done_vec(), 3'b000);
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    tick();
    check("rstw.no_done", done_vec(), 3'b000);
    rst_n = 1'b1;
    serve("after_rst", 3'b010, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
